// File: rtl/panel_framebuffer.sv
// panel_framebuffer: ping-pong frame memory. The front bank feeds two registered scan read ports,
// the back bank takes image writes, and bank swaps wait for frame_end. Option: PANEL_FB_BRIGHTNESS_EN.

`ifdef PANEL_FB_BRIGHTNESS_EN
module panel_fb_scale (
  input  logic [7:0] chan,
  input  logic [7:0] bright,
  output logic [7:0] scaled
);
  // (c*(bright+1))>>8 never exceeds 255, so the truncation loses nothing.
  assign scaled = 8'((16'(chan) * (16'(bright) + 16'd1)) >> 8);
endmodule
`endif

module panel_framebuffer #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PANEL_FB_BRIGHTNESS_EN
  input  logic [7:0]        bright,
`endif
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  input  logic              frame_end,
  output logic              swap_pending,
  output logic              front_bank,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr_top,
  input  logic [ADDR_W-1:0] addr_bottom,
  output logic [DATA_W-1:0] pix_top,
  output logic [DATA_W-1:0] pix_bottom,
  output logic              pix_valid
);
  localparam int NUM_CH = DATA_W / 8;
  localparam int DEPTH  = 2 ** (ADDR_W + 1);
`ifdef PANEL_FB_BRIGHTNESS_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic front_q, pending_q;
  logic front_nx, pending_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      front_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      front_q   <= front_nx;
      pending_q <= pending_nx;
    end
  end

  // A request coinciding with frame_end swaps at once; otherwise it waits for the next frame_end.
  always_comb begin
    front_nx   = front_q;
    pending_nx = pending_q;
    if (frame_end && (pending_q || swap_req)) begin
      front_nx   = ~front_q;
      pending_nx = 1'b0;
    end else if (swap_req) begin
      pending_nx = 1'b1;
    end
  end

  always_comb begin
    front_bank   = front_q;
    swap_pending = pending_q;
  end

  // Writes target the bank not being displayed, so they never collide with scan reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~front_q, wr_addr}] <= wr_data;
  end

  logic [STAGES:0]   vld_pipe;
  logic [DATA_W-1:0] rd_top, rd_bottom;

  assign vld_pipe[0] = rd_en;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_top    <= '0;
      rd_bottom <= '0;
    end else if (rd_en) begin
      rd_top    <= mem[{front_q, addr_top}];
      rd_bottom <= mem[{front_q, addr_bottom}];
    end
  end

`ifdef PANEL_FB_BRIGHTNESS_EN
  logic [1:0][NUM_CH-1:0][7:0] raw, scaled;

  assign raw = {rd_bottom, rd_top};

  for (genvar p = 0; p < 2; p++) begin : g_port
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      panel_fb_scale u_scale (
        .chan   (raw[p][c]),
        .bright (bright),
        .scaled (scaled[p][c])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_top    <= '0;
      pix_bottom <= '0;
    end else if (vld_pipe[1]) begin
      pix_top    <= scaled[0];
      pix_bottom <= scaled[1];
    end
  end
`else
  assign pix_top    = rd_top;
  assign pix_bottom = rd_bottom;
`endif

  assign pix_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_panel_framebuffer.sv
// Bench for panel_framebuffer: directed swap/read scenarios plus a randomized run checked against
// a bank-level behavioural model. Works with or without PANEL_FB_BRIGHTNESS_EN.

module tb_panel_framebuffer;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 12;
`ifdef PANEL_FB_BRIGHTNESS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, wr_en, swap_req, frame_end, rd_en;
  logic [ADDR_W-1:0] wr_addr, addr_top, addr_bottom;
  logic [DATA_W-1:0] wr_data, pix_top, pix_bottom;
  logic              swap_pending, front_bank, pix_valid;
  logic [7:0]        bright;

  int n_checks = 0;
  int n_pass   = 0;

  panel_framebuffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef PANEL_FB_BRIGHTNESS_EN
    .bright       (bright),
`endif
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .frame_end    (frame_end),
    .swap_pending (swap_pending),
    .front_bank   (front_bank),
    .rd_en        (rd_en),
    .addr_top     (addr_top),
    .addr_bottom  (addr_bottom),
    .pix_top      (pix_top),
    .pix_bottom   (pix_bottom),
    .pix_valid    (pix_valid)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a flat array of both banks, plus displayed bank and pending flag.
  logic [DATA_W-1:0] mref [2**(ADDR_W+1)];
  bit                wrote [2**(ADDR_W+1)];
  logic              m_front, m_pend;
  logic [DATA_W-1:0] e_top, e_bot, s1_top, s1_bot;
  bit                e_kt, e_kb, s1_kt, s1_kb, e_valid, s1_v;

  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] p, input logic [7:0] b);
    logic [DATA_W-1:0] r;
    for (int c = 0; c < DATA_W / 8; c++)
      r[c*8 +: 8] = 8'((int'(p[c*8 +: 8]) * (int'(b) + 1)) / 256);
    return r;
  endfunction

  // Advance the model by one edge using the currently driven inputs, then step the DUT.
  task automatic tick();
    int it, ib, iw;
    logic [DATA_W-1:0] rt, rb;
    bit kt, kb;
    it = int'({m_front, addr_top});
    ib = int'({m_front, addr_bottom});
    rt = mref[it]; kt = wrote[it];
    rb = mref[ib]; kb = wrote[ib];
    if (wr_en) begin
      iw = int'({~m_front, wr_addr});
      mref[iw]  = wr_data;
      wrote[iw] = 1'b1;
    end
    if (rst) begin
      m_front = 1'b0; m_pend = 1'b0;
      e_top = '0; e_bot = '0; e_kt = 1'b1; e_kb = 1'b1; e_valid = 1'b0;
      s1_v = 1'b0;
    end else begin
      if (LAT == 1) begin
        if (rd_en) begin e_top = rt; e_bot = rb; e_kt = kt; e_kb = kb; end
        e_valid = rd_en;
      end else begin
        if (s1_v) begin
          e_top = scale(s1_top, bright); e_bot = scale(s1_bot, bright);
          e_kt = s1_kt; e_kb = s1_kb;
        end
        e_valid = s1_v;
        if (rd_en) begin s1_top = rt; s1_bot = rb; s1_kt = kt; s1_kb = kb; end
        s1_v = rd_en;
      end
      if (frame_end && (m_pend || swap_req)) begin
        m_front = ~m_front;
        m_pend  = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wr_en = 1'b0; swap_req = 1'b0; frame_end = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; addr_top = '0; addr_bottom = '0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_swap_now();
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] at, input logic [ADDR_W-1:0] ab);
    rd_en = 1'b1; addr_top = at; addr_bottom = ab;
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (front_bank !== 1'b0) $display("FAIL reset_front got=%b want=0", front_bank); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL reset_pending got=%b want=0", swap_pending); else n_pass++;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", pix_valid); else n_pass++;
    n_checks++; if (pix_top !== '0 || pix_bottom !== '0)
      $display("FAIL reset_pix got=%h/%h want=0/0", pix_top, pix_bottom); else n_pass++;
    rd_en = 1'b1; addr_top = '0; addr_bottom = '0;
    tick();
    rd_en = 1'b0;
    if (LAT == 2) begin
      n_checks++; if (pix_valid !== 1'b0) $display("FAIL first_read_early_valid got=%b want=0", pix_valid); else n_pass++;
      tick();
    end
    n_checks++; if (pix_valid !== 1'b1) $display("FAIL first_read_valid got=%b want=1", pix_valid); else n_pass++;
    tick();
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL valid_drop got=%b want=0", pix_valid); else n_pass++;
  endtask

  task automatic test_deferred_swap();
    do_write(12'd5, 24'hFF0000);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (swap_pending !== 1'b1 || front_bank !== 1'b0)
        $display("FAIL pending_hold cyc=%0d got=%b/%b want=1/0", i, swap_pending, front_bank); else n_pass++;
      if (i < 2) tick();
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++; if (front_bank !== 1'b1 || swap_pending !== 1'b0)
      $display("FAIL swap_applied got=%b/%b want=1/0", front_bank, swap_pending); else n_pass++;
    do_read(12'd5, 12'd5);
    n_checks++; if (pix_valid !== 1'b1 || pix_top !== 24'hFF0000)
      $display("FAIL swap_read got=%b/%h want=1/ff0000", pix_valid, pix_top); else n_pass++;
  endtask

  task automatic test_same_cycle_swap();
    logic want;
    want = ~m_front;
    do_swap_now();
    n_checks++; if (front_bank !== want || swap_pending !== 1'b0)
      $display("FAIL same_cycle_swap got=%b/%b want=%b/0", front_bank, swap_pending, want); else n_pass++;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++; if (front_bank !== want)
      $display("FAIL idle_frame_end got=%b want=%b", front_bank, want); else n_pass++;
  endtask

  task automatic test_repeat_req();
    logic want;
    want = ~m_front;
    for (int i = 0; i < 3; i++) begin
      swap_req = 1'b1; tick();
      swap_req = 1'b0; tick();
    end
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL repeat_pending got=%b want=1", swap_pending); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      frame_end = 1'b1; tick();
      frame_end = 1'b0; tick();
    end
    n_checks++; if (front_bank !== want || swap_pending !== 1'b0)
      $display("FAIL repeat_one_toggle got=%b/%b want=%b/0", front_bank, swap_pending, want); else n_pass++;
  endtask

  task automatic test_addr_edges();
    do_write(12'hFFF, 24'h123456);
    do_write(12'h000, 24'h00FF00);
    do_swap_now();
    do_read(12'hFFF, 12'h000);
    n_checks++; if (pix_top !== 24'h123456 || pix_bottom !== 24'h00FF00)
      $display("FAIL addr_edges got=%h/%h want=123456/00ff00", pix_top, pix_bottom); else n_pass++;
  endtask

  task automatic test_brightness();
`ifdef PANEL_FB_BRIGHTNESS_EN
    bright = 8'd127;
    do_write(12'd7, 24'hFF8040);
    do_swap_now();
    rd_en = 1'b1; addr_top = 12'd7; addr_bottom = 12'd7;
    tick();
    rd_en = 1'b0;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL bright_early got=%b want=0", pix_valid); else n_pass++;
    tick();
    n_checks++; if (pix_valid !== 1'b1 || pix_top !== 24'h7F4020 || pix_bottom !== 24'h7F4020)
      $display("FAIL bright_127 got=%b/%h/%h want=1/7f4020/7f4020", pix_valid, pix_top, pix_bottom); else n_pass++;
    bright = 8'd0;
    do_read(12'd7, 12'd7);
    n_checks++; if (pix_top !== 24'h000000) $display("FAIL bright_0 got=%h want=000000", pix_top); else n_pass++;
    bright = 8'd255;
`endif
  endtask

  task automatic test_reset_pending();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL pre_reset_pending got=%b want=1", swap_pending); else n_pass++;
    rd_en = 1'b1; addr_top = 12'd5; addr_bottom = 12'd0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; rd_en = 1'b0;
    n_checks++; if (swap_pending !== 1'b0 || front_bank !== 1'b0)
      $display("FAIL reset_drops_swap got=%b/%b want=0/0", swap_pending, front_bank); else n_pass++;
    n_checks++; if (pix_valid !== 1'b0 || pix_top !== '0)
      $display("FAIL reset_drops_read got=%b/%h want=0/0", pix_valid, pix_top); else n_pass++;
    tick();
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL no_stale_valid got=%b want=0", pix_valid); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    // Fill addresses 0..15 in both banks so every random read has a known expected value.
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 16; a++) do_write(ADDR_W'(a), DATA_W'($urandom));
      do_swap_now();
    end
    for (int i = 0; i < 600; i++) begin
      wr_en       = 1'($urandom_range(0, 1));
      wr_addr     = ADDR_W'($urandom_range(0, 15));
      wr_data     = DATA_W'($urandom);
      swap_req    = ($urandom_range(0, 7) == 0);
      frame_end   = ($urandom_range(0, 5) == 0);
      rd_en       = 1'($urandom_range(0, 1));
      addr_top    = ADDR_W'($urandom_range(0, 15));
      addr_bottom = ADDR_W'($urandom_range(0, 15));
`ifdef PANEL_FB_BRIGHTNESS_EN
      bright      = 8'($urandom);
`endif
      tick();
      n_checks++;
      if (front_bank !== m_front || swap_pending !== m_pend || pix_valid !== e_valid) begin
        if (errs < 10) $display("FAIL rand_ctrl cyc=%0d got=%b%b%b want=%b%b%b", i,
                                front_bank, swap_pending, pix_valid, m_front, m_pend, e_valid);
        errs++;
      end else n_pass++;
      if (e_kt && e_kb) begin
        n_checks++;
        if (pix_top !== e_top || pix_bottom !== e_bot) begin
          if (errs < 10) $display("FAIL rand_pix cyc=%0d got=%h/%h want=%h/%h", i,
                                  pix_top, pix_bottom, e_top, e_bot);
          errs++;
        end else n_pass++;
      end
    end
    idle_inputs();
    bright = 8'd255;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2**(ADDR_W+1); i++) wrote[i] = 1'b0;
    m_front = 1'b0; m_pend = 1'b0;
    e_top = '0; e_bot = '0; e_kt = 1'b0; e_kb = 1'b0; e_valid = 1'b0;
    s1_top = '0; s1_bot = '0; s1_kt = 1'b0; s1_kb = 1'b0; s1_v = 1'b0;
    bright = 8'd255;
    idle_inputs();
    test_reset();
    test_deferred_swap();
    test_same_cycle_swap();
    test_repeat_req();
    test_addr_edges();
    test_brightness();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
